booth_radix_2: RTL and testbench



---
 rtl/booth_radix_2_pkg.sv | 23 ++
 rtl/booth_radix_2_addsub.sv | 22 ++
 rtl/booth_radix_2.sv | 108 ++++++++++
 tb/tb_booth_radix_2.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/booth_radix_2_pkg.sv
// Shared ALU definitions for the Booth radix-2 multiply unit.
//   WIDTH       - operand width of the multiplier datapath
//   ITERATIONS  - number of Booth steps per multiplication
//   booth_op_e  - encoding of the {Q[0], Qm1} recoding pair
package booth_radix_2_pkg;

    localparam int WIDTH      = 8;
    localparam int ITERATIONS = WIDTH;

    typedef enum logic [1:0] {
        BOOTH_NOP0 = 2'b00,
        BOOTH_ADD  = 2'b01,
        BOOTH_SUB  = 2'b10,
        BOOTH_NOP1 = 2'b11
    } booth_op_e;

    // Form the recoding pair from the multiplier LSB and the previously
    // shifted-out bit.
    function automatic booth_op_e booth_op(input logic q0, input logic qm1);
        return booth_op_e'({q0, qm1});
    endfunction

endpackage

// File: rtl/booth_radix_2_addsub.sv
// booth_addsub: ripple add/subtract built as invert-B plus carry-in.
// Ports:
//   a    (W)  first operand
//   b    (W)  second operand
//   sub  (1)  1 -> a - b, 0 -> a + b
//   sum  (W)  result, modulo 2^W
module booth_addsub #(
    parameter int W = booth_radix_2_pkg::WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff;

    // Two's-complement subtraction: ~b + 1, the +1 arriving as carry-in.
    assign b_eff = b ^ {W{sub}};
    assign sum   = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/booth_radix_2.sv
// booth_radix_2: iterative unsigned WIDTH x WIDTH multiplier using Booth
// radix-2 recoding over an {A, Q, Qm1} register pair. One Booth step per
// enabled clock; a final correction on the MSB turns the signed Booth
// result into the unsigned product.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, overrides start and enable
//   start    load operands and arm a new multiplication (aborts any current one)
//   enable   perform one Booth iteration this cycle
//   multA    multiplicand, unsigned
//   multB    multiplier, unsigned
//   done     product is valid; holds until the next start or rst
//   product  unsigned multA * multB
module booth_radix_2
    import booth_radix_2_pkg::*;
#(
    parameter int WIDTH = booth_radix_2_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               enable,
    input  logic [WIDTH-1:0]   multA,
    input  logic [WIDTH-1:0]   multB,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic signed [WIDTH:0]   acc;
    logic        [WIDTH:0]   mcand;
    logic        [WIDTH-1:0] mplier;
    logic                    qm1;
    logic        [CNT_W-1:0] cnt;
    logic                    busy;

    booth_op_e               op;
    logic        [WIDTH:0]   addsub_sum;
    logic        [WIDTH:0]   acc_step;
    logic        [WIDTH-1:0] corr_b;
    logic        [WIDTH-1:0] corr_hi;

    assign op = booth_op(mplier[0], qm1);

    booth_addsub #(.W(WIDTH + 1)) u_step_addsub (
        .a   (acc),
        .b   (mcand),
        .sub (op == BOOTH_SUB),
        .sum (addsub_sum)
    );

    always_comb begin
        acc_step = acc;
        case (op)
            BOOTH_ADD,
            BOOTH_SUB: acc_step = addsub_sum;
            default:   acc_step = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {1'b0, multA};
            mplier <= multB;
            qm1    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (enable && busy && !done) begin
            // Arithmetic right shift of {acc_step, Q, Qm1}, sign bit replicated.
            acc    <= {acc_step[WIDTH], acc_step[WIDTH:1]};
            mplier <= {acc_step[0], mplier[WIDTH-1:1]};
            qm1    <= mplier[0];
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Booth treats multB's MSB as a sign bit. After all shifts Qm1 holds that
    // original MSB, so adding the latched multiplicand << WIDTH restores the
    // unsigned product. The low half of the correction is zero, so only the
    // upper half needs an adder.
    assign corr_b = qm1 ? mcand[WIDTH-1:0] : '0;

    booth_addsub #(.W(WIDTH)) u_corr_addsub (
        .a   (acc[WIDTH-1:0]),
        .b   (corr_b),
        .sub (1'b0),
        .sum (corr_hi)
    );

    assign product = {corr_hi, mplier};

endmodule

// File: tb/tb_booth_radix_2.sv
// Directed testbench for booth_radix_2 with hand-computed expected products.
module tb_booth_radix_2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        enable;
    logic [7:0]  multA;
    logic [7:0]  multB;
    logic        done;
    logic [15:0] product;

    int errors;
    int checks;

    booth_radix_2 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .enable  (enable),
        .multA   (multA),
        .multB   (multB),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        multA = a; multB = b; start = 1'b1; enable = 1'b0;
        tick();
        start = 1'b0;
        multA = 8'hxx; multB = 8'hxx;
    endtask

    // Run n enabled cycles, checking done stays low except on the final
    // iteration edge when final_done is set.
    task automatic run_enabled(input string tag, input int n, input bit final_done);
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1 && final_done)
                check({tag, "_done_final"}, {31'b0, done}, 32'd1);
            else
                check({tag, "_done_early"}, {31'b0, done}, 32'd0);
        end
        enable = 1'b0;
    endtask

    task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
        do_reset();
        load(a, b);
        run_enabled(tag, 8, 1'b1);
        check({tag, "_product"}, {16'b0, product}, {16'b0, exp});
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; start = 1'b0; enable = 1'b0; multA = '0; multB = '0;

        // Reset state
        do_reset();
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_product", {16'b0, product}, 32'd0);

        // enable while idle after reset is ignored
        enable = 1'b1;
        tick(); tick(); tick();
        enable = 1'b0;
        check("idle_en_done", {31'b0, done}, 32'd0);
        check("idle_en_product", {16'b0, product}, 32'd0);

        mul("m15x3",   8'd15,  8'd3,   16'd45);
        mul("m7x8",    8'd7,   8'd8,   16'd56);
        mul("m255x255", 8'd255, 8'd255, 16'd65025);
        mul("m128x255", 8'd128, 8'd255, 16'd32640);
        mul("m0x200",  8'd0,   8'd200, 16'd0);
        mul("m1x1",    8'd1,   8'd1,   16'd1);
        mul("m200x128", 8'd200, 8'd128, 16'd25600);

        // Stall: 4 enabled, 3 stalled, 4 enabled
        do_reset();
        load(8'd9, 8'd13);
        run_enabled("stall_a", 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_done", {31'b0, done}, 32'd0);
        end
        run_enabled("stall_b", 4, 1'b1);
        check("stall_product", {16'b0, product}, 32'd117);
        // Extra enables after done change nothing
        enable = 1'b1;
        tick(); tick();
        enable = 1'b0;
        check("post_done_done", {31'b0, done}, 32'd1);
        check("post_done_product", {16'b0, product}, 32'd117);

        // Restart mid-operation with new operands
        do_reset();
        load(8'd200, 8'd100);
        run_enabled("restart_a", 4, 1'b0);
        load(8'd5, 8'd6);
        check("restart_done_clear", {31'b0, done}, 32'd0);
        run_enabled("restart_b", 8, 1'b1);
        check("restart_product", {16'b0, product}, 32'd30);

        // Restart after completion clears done
        load(8'd3, 8'd4);
        check("reload_done_clear", {31'b0, done}, 32'd0);
        run_enabled("reload", 8, 1'b1);
        check("reload_product", {16'b0, product}, 32'd12);

        // Reset mid-operation at iteration 5
        do_reset();
        load(8'd9, 8'd13);
        run_enabled("rst_mid", 5, 1'b0);
        rst = 1'b1; enable = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0;
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_product", {16'b0, product}, 32'd0);
        enable = 1'b1;
        tick(); tick(); tick(); tick();
        enable = 1'b0;
        check("rst_mid_idle_done", {31'b0, done}, 32'd0);
        check("rst_mid_idle_product", {16'b0, product}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
